// File: rtl/stepper_pkg.sv
// Shared types and sizing helpers for the stepper pulse generator.
// Imported by the axis slice and the top-level sequencer.
package stepper_pkg;

  localparam int POS_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE_HI,
    PULSE_LO,
    DONE
  } state_t;

  function automatic int timerWidth(input int div);
    return $clog2(div) + 1;
  endfunction

endpackage

// File: rtl/stepper_pulse_gen_if.sv
// Aim-pose handshake between the planner and the pulse generator.
// The planner drives the master side, the generator the slave side.
interface stepper_pulse_gen_if #(
  parameter int N = 6
);

  logic [32*N-1:0] aimPosition;
  logic            aimValid;
  logic            aimReady;

  modport master (
    output aimPosition,
    output aimValid,
    input  aimReady
  );

  modport slave (
    input  aimPosition,
    input  aimValid,
    output aimReady
  );

endinterface

// File: rtl/stepper_axis.sv
// One stepper axis: position counter, latched target, direction and
// step pulse register, driven by strobes from the sequencer.
module stepper_axis
  import stepper_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             load,
  input  logic             preset,
  input  logic             step,
  input  logic             clear,
  input  logic [POS_W-1:0] aim,
  input  logic [POS_W-1:0] presetValue,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             stepPulse,
  output logic             atTarget
);

  logic [POS_W-1:0] target;

  assign atTarget = (pos == target);

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      pos       <= '0;
      target    <= '0;
      dir       <= 1'b0;
      stepPulse <= 1'b0;
    end else begin
      if (load) begin
        target <= aim;
        dir    <= $signed(aim) > $signed(pos);
      end else if (preset) begin
        pos <= presetValue;
      end
      // Position moves on the same edge the pulse rises.
      if (step) begin
        stepPulse <= !atTarget;
        if (!atTarget)
          pos <= dir ? pos + 1'b1 : pos - 1'b1;
      end else if (clear) begin
        stepPulse <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/stepper_pulse_gen.sv
// Step/dir pulse sequencer: accepts one aim pose at a time and steps
// all axes concurrently until each reaches its target or abort.
module stepper_pulse_gen
  import stepper_pkg::*;
#(
  parameter int STEPPERS_NUM = 6,
  parameter int PULSE_DIV    = 16,
  parameter int PULSE_HIGH   = 4
) (
  input  logic                            CLK,
  input  logic                            RST_n,
  stepper_pulse_gen_if.slave              aimIf,
  input  logic                            abort,
  input  logic                            posLoad,
  input  logic [POS_W*STEPPERS_NUM-1:0]   posLoadValue,
  output logic [POS_W*STEPPERS_NUM-1:0]   stepperPosition,
  output logic [STEPPERS_NUM-1:0]         stepOut,
  output logic [STEPPERS_NUM-1:0]         dirOut,
  output logic                            moveBusy,
  output logic                            moveDone
);

  localparam int TW = timerWidth(PULSE_DIV);
  localparam logic [TW-1:0] HI_LEN = TW'(PULSE_HIGH - 1);
  localparam logic [TW-1:0] LO_LEN = TW'(PULSE_DIV - PULSE_HIGH - 1);

  state_t                  state;
  logic [TW-1:0]           timer;
  logic                    abortFlag;
  logic [STEPPERS_NUM-1:0] atTarget;
  logic                    isIdle;
  logic                    xfer;
  logic                    phaseEnd;
  logic                    abortNow;
  logic                    finish;
  logic                    stepStb;
  logic                    clearStb;
  logic                    presetStb;

  assign isIdle         = (state == IDLE);
  assign aimIf.aimReady = isIdle;
  assign xfer           = aimIf.aimValid && isIdle;
  assign phaseEnd       = (timer == '0);
  assign abortNow       = abortFlag || abort;
  assign finish         = (&atTarget) || abortNow;
  assign stepStb        = phaseEnd && !finish &&
                          (state == SETUP || state == PULSE_LO);
  assign clearStb       = phaseEnd && (state == PULSE_HI);
  assign presetStb      = posLoad && isIdle && !aimIf.aimValid;

  for (genvar i = 0; i < STEPPERS_NUM; i++) begin : g_axis
    stepper_axis u_axis (
      .CLK         (CLK),
      .RST_n       (RST_n),
      .load        (xfer),
      .preset      (presetStb),
      .step        (stepStb),
      .clear       (clearStb),
      .aim         (aimIf.aimPosition[POS_W*i +: POS_W]),
      .presetValue (posLoadValue[POS_W*i +: POS_W]),
      .pos         (stepperPosition[POS_W*i +: POS_W]),
      .dir         (dirOut[i]),
      .stepPulse   (stepOut[i]),
      .atTarget    (atTarget[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state     <= IDLE;
      timer     <= '0;
      abortFlag <= 1'b0;
      moveBusy  <= 1'b0;
      moveDone  <= 1'b0;
    end else begin
      moveDone <= 1'b0;
      unique case (state)
        IDLE: begin
          abortFlag <= 1'b0;
          if (xfer) begin
            state    <= SETUP;
            timer    <= HI_LEN;
            moveBusy <= 1'b1;
          end
        end
        SETUP, PULSE_LO: begin
          abortFlag <= abortNow;
          if (!phaseEnd) begin
            timer <= timer - 1'b1;
          end else if (finish) begin
            state    <= DONE;
            moveBusy <= 1'b0;
            moveDone <= 1'b1;
          end else begin
            state <= PULSE_HI;
            timer <= HI_LEN;
          end
        end
        PULSE_HI: begin
          abortFlag <= abortNow;
          if (!phaseEnd) begin
            timer <= timer - 1'b1;
          end else begin
            state <= PULSE_LO;
            timer <= LO_LEN;
          end
        end
        DONE: begin
          abortFlag <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
